// File: rtl/fpu_exc_ctrl_if.sv
// Result/CSR/commit/trap signal bundle between the FPU pipeline, core and fpu_exc_ctrl.
// The master drives results, CSR writes and trap_ack; the slave is the exception controller.
`timescale 1ns/1ps
interface fpu_exc_ctrl_if;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_ieeep;
  logic [3:0]  res_tag;
  logic        csr_we;
  logic [9:0]  csr_wdata;
  logic [17:0] csr_rdata;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic        trap_req;
  logic [4:0]  trap_cause;
  logic [3:0]  trap_tag;
  logic        trap_ack;

  modport master (
    output res_valid, res_ieeep, res_tag, csr_we, csr_wdata, trap_ack,
    input  res_ready, csr_rdata, commit_valid, commit_tag, trap_req, trap_cause, trap_tag
  );

  modport slave (
    input  res_valid, res_ieeep, res_tag, csr_we, csr_wdata, trap_ack,
    output res_ready, csr_rdata, commit_valid, commit_tag, trap_req, trap_cause, trap_tag
  );
endinterface

// File: rtl/fpu_exc_ctrl.sv
// IEEE exception controller: sticky flags, per-exception trap enables, commit/trap sequencing.
// Optional saturating trap counter enabled by defining FPU_EXC_TRAP_CNT_EN.
`timescale 1ns/1ps
module fpu_exc_ctrl (
  input  logic          clk,
  input  logic          rst,
  fpu_exc_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  flags_reg, flags_next;
  logic [4:0]  trap_en_reg, trap_en_next;
  logic [4:0]  trap_cause_reg, trap_cause_next;
  logic [3:0]  trap_tag_reg, trap_tag_next;
  logic        commit_valid_reg, commit_valid_next;
  logic [3:0]  commit_tag_reg, commit_tag_next;
  logic [4:0]  trap_hit;
  logic [4:0]  flags_base;
  logic        accept;
  logic        trap_any;
  logic [7:0]  trap_cnt;

  assign accept   = bus.res_valid & (state_reg == IDLE);
  assign trap_any = |trap_hit;

  // A software write replaces flags first, then the accepted result ORs its bits on top.
  // The trap decision always uses the enables as they were before any write this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_exc_bit
      assign trap_hit[gi]     = bus.res_ieeep[gi] & trap_en_reg[gi];
      assign flags_base[gi]   = bus.csr_we ? bus.csr_wdata[gi] : flags_reg[gi];
      assign flags_next[gi]   = flags_base[gi] | (accept & bus.res_ieeep[gi]);
      assign trap_en_next[gi] = bus.csr_we ? bus.csr_wdata[5+gi] : trap_en_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    trap_cause_next   = trap_cause_reg;
    trap_tag_next     = trap_tag_reg;
    commit_valid_next = 1'b0;
    commit_tag_next   = commit_tag_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (trap_any) begin
            state_next      = TRAP;
            trap_cause_next = trap_hit;
            trap_tag_next   = bus.res_tag;
          end else begin
            commit_valid_next = 1'b1;
            commit_tag_next   = bus.res_tag;
          end
        end
      end
      TRAP: begin
        if (bus.trap_ack) begin
          state_next      = IDLE;
          trap_cause_next = 5'd0;
          trap_tag_next   = 4'd0;
        end
      end
      default: begin
        state_next      = IDLE;
        trap_cause_next = 5'd0;
        trap_tag_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      flags_reg        <= 5'd0;
      trap_en_reg      <= 5'd0;
      trap_cause_reg   <= 5'd0;
      trap_tag_reg     <= 4'd0;
      commit_valid_reg <= 1'b0;
      commit_tag_reg   <= 4'd0;
    end else begin
      state_reg        <= state_next;
      flags_reg        <= flags_next;
      trap_en_reg      <= trap_en_next;
      trap_cause_reg   <= trap_cause_next;
      trap_tag_reg     <= trap_tag_next;
      commit_valid_reg <= commit_valid_next;
      commit_tag_reg   <= commit_tag_next;
    end
  end

`ifdef FPU_EXC_TRAP_CNT_EN
  logic [7:0] trap_cnt_reg;
  logic       enter_trap;

  assign enter_trap = (state_reg == IDLE) && (state_next == TRAP);

  // Clearing by a CSR write wins over a simultaneous trap entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_cnt_reg <= 8'd0;
    end else if (bus.csr_we) begin
      trap_cnt_reg <= 8'd0;
    end else if (enter_trap && (trap_cnt_reg != 8'hFF)) begin
      trap_cnt_reg <= trap_cnt_reg + 8'd1;
    end
  end

  assign trap_cnt = trap_cnt_reg;
`else
  assign trap_cnt = 8'd0;
`endif

  assign bus.res_ready    = (state_reg == IDLE);
  assign bus.trap_req     = (state_reg == TRAP);
  assign bus.trap_cause   = trap_cause_reg;
  assign bus.trap_tag     = trap_tag_reg;
  assign bus.commit_valid = commit_valid_reg;
  assign bus.commit_tag   = commit_tag_reg;
  assign bus.csr_rdata    = {trap_cnt, trap_en_reg, flags_reg};

endmodule

// File: tb/tb_fpu_exc_ctrl.sv
// Scoreboard bench for fpu_exc_ctrl: directed scenarios, a randomized model-checked phase,
// the trap-counter saturation run and reset during a pending trap.
`timescale 1ns/1ps
module tb_fpu_exc_ctrl;

  typedef struct {
    logic [3:0] tag;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  fpu_exc_ctrl_if bus();

  fpu_exc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t q[$];

  logic [4:0] flags_m, en_m, cause_m, ieeep_r, hit_r;
  logic [3:0] tag_m, tag_r;
  logic       trap_m, v_r, we_r, ack_r, acc_r;
  logic [9:0] wdata_r;
  int         cnt_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_commit(input logic [3:0] tag);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.res_valid = 1'b0;
    bus.res_ieeep = 5'd0;
    bus.res_tag   = 4'd0;
    bus.csr_we    = 1'b0;
    bus.csr_wdata = 10'd0;
    bus.trap_ack  = 1'b0;
  endtask

  function automatic logic [7:0] cnt_exp(input int c);
`ifdef FPU_EXC_TRAP_CNT_EN
    return c[7:0];
`else
    return 8'd0;
`endif
  endfunction

  // Commit monitor: every pulse must match the oldest expected tag on its expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.commit_valid) begin
        if (q.size() == 0) begin
          check_val("spurious_commit", {28'd0, bus.commit_tag}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check_val("commit_tag", {28'd0, bus.commit_tag}, {28'd0, e.tag});
          check_val("commit_cycle", cyc, e.cyc);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check_val("missing_commit", 0, 1);
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_ready", bus.res_ready, 1);
    check_val("rst_rdata", bus.csr_rdata, 0);
    check_val("rst_commit_valid", bus.commit_valid, 0);
    check_val("rst_commit_tag", bus.commit_tag, 0);
    check_val("rst_trap_req", bus.trap_req, 0);
    check_val("rst_trap_cause", bus.trap_cause, 0);
    check_val("rst_trap_tag", bus.trap_tag, 0);
    rst = 1'b0;

    // Two back-to-back non-trapping results
    bus.res_valid = 1'b1; bus.res_ieeep = 5'b00001; bus.res_tag = 4'd3; push_commit(4'd3);
    @(negedge clk);
    bus.res_ieeep = 5'b00010; bus.res_tag = 4'd4; push_commit(4'd4);
    @(negedge clk);
    bus.res_valid = 1'b0;
    @(negedge clk);
    check_val("b2b_flags", bus.csr_rdata[4:0], 5'b00011);

    // Enabled exception traps
    bus.csr_we = 1'b1; bus.csr_wdata = {5'b01000, 5'b00000};
    @(negedge clk);
    bus.csr_we = 1'b0;
    bus.res_valid = 1'b1; bus.res_ieeep = 5'b01001; bus.res_tag = 4'd7;
    @(negedge clk);
    bus.res_valid = 1'b0;
    check_val("trap_req", bus.trap_req, 1);
    check_val("trap_cause", bus.trap_cause, 5'b01000);
    check_val("trap_tag", bus.trap_tag, 4'd7);
    check_val("trap_ready", bus.res_ready, 0);
    check_val("trap_rdata", bus.csr_rdata[9:0], {5'b01000, 5'b01001});

    // Result held during TRAP is stalled until after the ack
    bus.res_valid = 1'b1; bus.res_ieeep = 5'b00000; bus.res_tag = 4'd9;
    repeat (5) begin
      @(negedge clk);
      check_val("hold_ready", bus.res_ready, 0);
      check_val("hold_trap_req", bus.trap_req, 1);
    end
    bus.trap_ack = 1'b1;
    @(negedge clk);
    bus.trap_ack = 1'b0;
    check_val("ack_trap_req", bus.trap_req, 0);
    check_val("ack_trap_cause", bus.trap_cause, 0);
    check_val("ack_trap_tag", bus.trap_tag, 0);
    check_val("ack_ready", bus.res_ready, 1);
    push_commit(4'd9);
    @(negedge clk);
    bus.res_valid = 1'b0;

    // trap_ack while IDLE has no effect
    bus.trap_ack = 1'b1;
    bus.res_valid = 1'b1; bus.res_ieeep = 5'b00100; bus.res_tag = 4'd2; push_commit(4'd2);
    @(negedge clk);
    idle_inputs();
    check_val("idle_ack_trap_req", bus.trap_req, 0);
    check_val("idle_ack_ready", bus.res_ready, 1);

    // CSR write coinciding with acceptance
    bus.csr_we = 1'b1; bus.csr_wdata = 10'd0;
    bus.res_valid = 1'b1; bus.res_ieeep = 5'b10000; bus.res_tag = 4'd5; push_commit(4'd5);
    @(negedge clk);
    idle_inputs();
    check_val("wr_acc_rdata", bus.csr_rdata[9:0], {5'b00000, 5'b10000});

    // Trap decision uses the enables from before a coinciding write
    bus.csr_we = 1'b1; bus.csr_wdata = {5'b00001, 5'b00000};
    @(negedge clk);
    bus.csr_wdata = 10'd0;
    bus.res_valid = 1'b1; bus.res_ieeep = 5'b00001; bus.res_tag = 4'd6;
    @(negedge clk);
    idle_inputs();
    check_val("pre_en_trap_req", bus.trap_req, 1);
    check_val("pre_en_trap_cause", bus.trap_cause, 5'b00001);
    check_val("pre_en_trap_tag", bus.trap_tag, 4'd6);
    check_val("pre_en_rdata", bus.csr_rdata[9:0], {5'b00000, 5'b00001});
    bus.trap_ack = 1'b1;
    @(negedge clk);
    bus.trap_ack = 1'b0;

    // Randomized phase checked against a behavioural model
    bus.csr_we = 1'b1; bus.csr_wdata = {5'b00110, 5'b00000};
    @(negedge clk);
    bus.csr_we = 1'b0;
    flags_m = 5'd0; en_m = 5'b00110; trap_m = 1'b0; cause_m = 5'd0; tag_m = 4'd0; cnt_m = 0;
    for (int i = 0; i < 200; i++) begin
      check_val("rnd_ready", bus.res_ready, !trap_m);
      check_val("rnd_trap_req", bus.trap_req, trap_m);
      check_val("rnd_trap_cause", bus.trap_cause, cause_m);
      check_val("rnd_trap_tag", bus.trap_tag, tag_m);
      check_val("rnd_rdata", bus.csr_rdata, {cnt_exp(cnt_m), en_m, flags_m});
      v_r     = ($urandom_range(0, 3) != 0);
      ieeep_r = 5'($urandom);
      tag_r   = 4'($urandom);
      we_r    = ($urandom_range(0, 7) == 0);
      wdata_r = 10'($urandom);
      ack_r   = ($urandom_range(0, 2) == 0);
      bus.res_valid = v_r; bus.res_ieeep = ieeep_r; bus.res_tag = tag_r;
      bus.csr_we = we_r; bus.csr_wdata = wdata_r; bus.trap_ack = ack_r;
      acc_r = v_r && !trap_m;
      hit_r = ieeep_r & en_m;
      if (acc_r && hit_r == 5'd0) push_commit(tag_r);
      if (we_r) cnt_m = 0;
      else if (acc_r && hit_r != 5'd0 && cnt_m < 255) cnt_m++;
      flags_m = (we_r ? wdata_r[4:0] : flags_m) | (acc_r ? ieeep_r : 5'd0);
      en_m    = we_r ? wdata_r[9:5] : en_m;
      if (!trap_m && acc_r && hit_r != 5'd0) begin
        trap_m = 1'b1; cause_m = hit_r; tag_m = tag_r;
      end else if (trap_m && ack_r) begin
        trap_m = 1'b0; cause_m = 5'd0; tag_m = 4'd0;
      end
      @(negedge clk);
    end
    idle_inputs();
    bus.trap_ack = 1'b1;
    @(negedge clk);
    bus.trap_ack = 1'b0;
    @(negedge clk);

    // Trap counter: 260 trap/ack sequences
    bus.csr_we = 1'b1; bus.csr_wdata = {5'b00001, 5'b00000};
    @(negedge clk);
    bus.csr_we = 1'b0;
    check_val("cnt_cleared", bus.csr_rdata[17:10], 0);
    for (int k = 0; k < 260; k++) begin
      bus.res_valid = 1'b1; bus.res_ieeep = 5'b00001; bus.res_tag = 4'(k);
      @(negedge clk);
      bus.res_valid = 1'b0; bus.trap_ack = 1'b1;
      @(negedge clk);
      bus.trap_ack = 1'b0;
      if (k == 2) check_val("cnt_after_3", bus.csr_rdata[17:10], cnt_exp(3));
    end
    check_val("cnt_saturated", bus.csr_rdata[17:10], cnt_exp(255));
    check_val("cnt_flags", bus.csr_rdata[4:0], 5'b00001);

    // Reset while a trap is pending
    bus.csr_we = 1'b1; bus.csr_wdata = {5'b00010, 5'b00000};
    @(negedge clk);
    bus.csr_we = 1'b0;
    bus.res_valid = 1'b1; bus.res_ieeep = 5'b00010; bus.res_tag = 4'd11;
    @(negedge clk);
    bus.res_valid = 1'b0;
    check_val("pre_rst_trap_req", bus.trap_req, 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_trap_req", bus.trap_req, 0);
    check_val("mid_rst_trap_cause", bus.trap_cause, 0);
    check_val("mid_rst_trap_tag", bus.trap_tag, 0);
    check_val("mid_rst_rdata", bus.csr_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    check_val("post_rst_ready", bus.res_ready, 1);
    check_val("post_rst_flags", bus.csr_rdata[4:0], 0);
    check_val("post_rst_commit_valid", bus.commit_valid, 0);
    bus.res_valid = 1'b1; bus.res_ieeep = 5'b00000; bus.res_tag = 4'd12; push_commit(4'd12);
    @(negedge clk);
    bus.res_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_exc_ctrl.md
FPU_EXC_CTRL -- requirements
Module: fpu_exc_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port res_valid  in  1  rounder result carrying exception vector presented.
REQ-004 SHALL have port res_ready  out  1  controller can accept a result this cycle.
REQ-005 SHALL have port res_ieeep  in  5  rounder exception vector {INV,DBZ,OVF,UNF,INX}.
REQ-006 SHALL have port res_tag  in  4  operation identifier of the presented result.
REQ-007 SHALL have port csr_we  in  1  software write strobe for the status/control register.
REQ-008 SHALL have port csr_wdata  in  10  write data {trap_en[4:0], flags[4:0]}.
REQ-009 SHALL have port csr_rdata  out  18  read data {trap_cnt[7:0], trap_en[4:0], flags[4:0]}.
REQ-010 SHALL have port commit_valid  out  1  one-cycle pulse: non-trapping result retired.
REQ-011 SHALL have port commit_tag  out  4  tag of the retired result, valid with commit_valid.
REQ-012 SHALL have port trap_req  out  1  trap pending toward core; held until acknowledged.
REQ-013 SHALL have port trap_cause  out  5  res_ieeep AND trap_en of the trapping result.
REQ-014 SHALL have port trap_tag  out  4  tag of the trapping result.
REQ-015 SHALL have port trap_ack  in  1  core acknowledges the pending trap.

Function
REQ-016 SHALL implement FSM states IDLE and TRAP; res_ready SHALL be 1 in IDLE, 0 in TRAP.
REQ-017 SHALL accept a result when res_valid & res_ready are both 1 in the same cycle; no other condition accepts.
REQ-018 On acceptance, flags SHALL become flags | res_ieeep at the next edge (sticky).
REQ-019 On acceptance with (res_ieeep & trap_en) == 0: state stays IDLE; commit_valid=1 and commit_tag=res_tag in the following cycle only.
REQ-020 On acceptance with (res_ieeep & trap_en) != 0: next state TRAP; trap_cause, trap_tag latched; trap_req=1 from the next cycle; no commit_valid for that tag.
REQ-021 In TRAP, trap_ack=1 SHALL return the FSM to IDLE at the next edge; trap_req, trap_cause, trap_tag SHALL clear to 0 at that edge.
REQ-022 trap_ack in IDLE SHALL be ignored.
REQ-023 Back-to-back non-trapping results SHALL be accepted every cycle (one per clock throughput).
REQ-024 csr_we SHALL load trap_en and flags from csr_wdata at the next edge.
REQ-025 csr_we coinciding with acceptance: flags SHALL become csr_wdata[4:0] | res_ieeep; trap decision SHALL use the pre-write trap_en.
REQ-026 csr_rdata SHALL reflect current registered values combinationally; trap_cnt field reads 0 when counter not compiled in.

Reset
REQ-027 While rst=1: state=IDLE, flags=0, trap_en=0, trap_cnt=0, commit_valid=0, commit_tag=0, trap_req=0, trap_cause=0, trap_tag=0.
REQ-028 Reset asserted mid-trap SHALL discard the pending trap; first cycle after release res_ready=1.

Configuration
REQ-029 Macro FPU_EXC_TRAP_CNT_EN defined: 8-bit trap_cnt SHALL increment on each IDLE->TRAP transition, saturate at 255, clear on csr_we.
REQ-030 Macro FPU_EXC_TRAP_CNT_EN undefined: no counter register SHALL exist; csr_rdata[17:10] tied to 0.

Verification
REQ-031 trap_en=0, results ieeep=5'b00001 tag 3 then 5'b00010 tag 4 consecutive -> commit pulses tags 3,4 on consecutive cycles; flags=5'b00011.
REQ-032 csr write trap_en=5'b01000, result ieeep=5'b01001 tag 7 -> trap_req=1, trap_cause=5'b01000, trap_tag=7, res_ready=0, no commit; flags=5'b01001.
REQ-033 In TRAP hold res_valid=1 tag 9 for 5 cycles, then trap_ack -> tag 9 not accepted until cycle after ack; then commits tag 9.
REQ-034 csr_we wdata flags=0 same cycle as accepted ieeep=5'b10000 -> flags=5'b10000.
REQ-035 FPU_EXC_TRAP_CNT_EN defined, 260 trap/ack sequences -> trap_cnt=255; undefined -> csr_rdata[17:10]=0.
REQ-036 rst pulse while trap_req=1 -> all outputs 0, res_ready=1 next cycle, flags=0.
